// File: rtl/nibble_serial_adder_pkg.sv
// rtl/nibble_serial_adder_pkg.sv - shared ALU constants and sequencing state encoding
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_cla.sv
// rtl/nibble_serial_adder_cla.sv - 4-bit carry-lookahead adder with group propagate/generate
module CLA_4bit (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout,
    output logic       Xout,
    output logic       Yout
);

    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;

    assign p = A ^ B;
    assign g = A & B;

    assign c[0] = Cin;
    assign c[1] = g[0] | (p[0] & Cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & Cin);

    // Xout/Yout are the group propagate/generate terms for cascading into a higher-level lookahead
    assign Xout = &p;
    assign Yout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

    assign Cout = Yout | (Xout & Cin);
    assign Sum  = p ^ c;

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - multi-cycle adder stepping one nibble per clock through a single CLA_4bit
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int NIB  = WIDTH / NIBBLE_W;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NIB - 1);

    generate
        if ((WIDTH < NIBBLE_W) || ((WIDTH % NIBBLE_W) != 0)) begin : g_bad_width
            $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    state_t            state;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic [WIDTH-1:0]  sum_reg;
    logic [WIDTH-1:0]  sum_next;
    logic              carry_reg;
    logic [IDXW-1:0]   idx;
    logic              out_valid_reg;
    logic              cout_reg;
    logic              overflow_reg;
    logic              zero_reg;

    logic [IDXW+1:0]     bit_base;
    logic [NIBBLE_W-1:0] cla_sum;
    logic                cla_cout;

    assign bit_base = {idx, 2'b00};

    CLA_4bit u_cla (
        .A    (a_reg[bit_base +: NIBBLE_W]),
        .B    (b_reg[bit_base +: NIBBLE_W]),
        .Cin  (carry_reg),
        .Sum  (cla_sum),
        .Cout (cla_cout),
        .Xout (),
        .Yout ()
    );

    // Sum as it will be after this edge, so the final flags see the nibble being written
    always_comb begin
        sum_next = sum_reg;
        sum_next[bit_base +: NIBBLE_W] = cla_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            sum_reg       <= '0;
            carry_reg     <= 1'b0;
            idx           <= '0;
            out_valid_reg <= 1'b0;
            cout_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
            zero_reg      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= cin;
                        idx       <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    sum_reg   <= sum_next;
                    carry_reg <= cla_cout;
                    if (idx == LAST) begin
                        state         <= DONE;
                        out_valid_reg <= 1'b1;
                        cout_reg      <= cla_cout;
                        overflow_reg  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                         (sum_next[WIDTH-1] != a_reg[WIDTH-1]);
                        zero_reg      <= (sum_next == '0);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = out_valid_reg;
    assign sum       = sum_reg;
    assign cout      = cout_reg;
    assign overflow  = overflow_reg;
    assign zero      = zero_reg;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - randomized self-checking bench for 16-bit and 4-bit adders
module tb_nibble_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, cin, cout, overflow, zero;
    logic [15:0] a, b, sum;
    logic        in_valid4, in_ready4, out_valid4, out_ready4, cin4, cout4, overflow4, zero4;
    logic [3:0]  a4, b4, sum4;

    int errors = 0;
    int checks = 0;

    nibble_serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .overflow(overflow), .zero(zero)
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4), .overflow(overflow4), .zero(zero4)
    );

    // Reference: plain integer addition, signed overflow judged by the true signed result range
    function automatic void model(input int w, input int av, input int bv, input int cv,
                                  output int es, output int ec, output int eo, output int ez);
        int m, tot, sa, sb, st;
        m   = 1 << w;
        tot = av + bv + cv;
        sa  = (av >= m / 2) ? av - m : av;
        sb  = (bv >= m / 2) ? bv - m : bv;
        st  = sa + sb + cv;
        es  = tot % m;
        ec  = tot / m;
        eo  = ((st >= m / 2) || (st < -(m / 2))) ? 1 : 0;
        ez  = (es == 0) ? 1 : 0;
    endfunction

    task automatic op16(input logic [15:0] av, input logic [15:0] bv, input logic cv, output int lat);
        int t;
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1; t++;
        end
        a = av; b = bv; cin = cv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic op4(input logic [3:0] av, input logic [3:0] bv, input logic cv, output int lat);
        int t;
        t = 0;
        while (!in_ready4 && t < 50) begin
            @(posedge clk); #1; t++;
        end
        a4 = av; b4 = bv; cin4 = cv; in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        lat = 0;
        while (!out_valid4 && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 0; a = '0; b = '0; cin = 0; out_ready = 1'b1;
        in_valid4 = 0; a4 = '0; b4 = '0; cin4 = 0; out_ready4 = 1'b1;
        #12;
        checks++;
        if ({in_ready, out_valid, sum, cout, overflow, zero} !== {1'b1, 1'b0, 16'h0, 3'b000}) begin
            errors++;
            $display("FAIL reset16: got rdy=%b vld=%b sum=%h c=%b o=%b z=%b want rdy=1 vld=0 sum=0000 flags=000",
                     in_ready, out_valid, sum, cout, overflow, zero);
        end
        checks++;
        if ({in_ready4, out_valid4, sum4, cout4, overflow4, zero4} !== {1'b1, 1'b0, 4'h0, 3'b000}) begin
            errors++;
            $display("FAIL reset4: got rdy=%b vld=%b sum=%h want rdy=1 vld=0 sum=0", in_ready4, out_valid4, sum4);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [15:0] va [5] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h8000, 16'hFFFF};
        logic [15:0] vb [5] = '{16'h4321, 16'h0001, 16'h0000, 16'h8000, 16'hFFFF};
        logic        vc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int lat, es, ec, eo, ez;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            model(16, va[i], vb[i], vc[i], es, ec, eo, ez);
            op16(va[i], vb[i], vc[i], lat);
            checks++;
            if (lat !== 4) begin
                errors++; $display("FAIL dir%0d_latency: got %0d want 4", i, lat);
            end
            checks++;
            if ({sum, cout, overflow, zero} !== {16'(es), 1'(ec), 1'(eo), 1'(ez)}) begin
                errors++;
                $display("FAIL dir%0d_result: got sum=%h c=%b o=%b z=%b want sum=%h c=%0d o=%0d z=%0d",
                         i, sum, cout, overflow, zero, 16'(es), ec, eo, ez);
            end
            @(posedge clk); #1;
            checks++;
            if ({out_valid, in_ready} !== 2'b01) begin
                errors++; $display("FAIL dir%0d_release: got vld=%b rdy=%b want vld=0 rdy=1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_random();
        int lat, es, ec, eo, ez, hold;
        logic [15:0] ra, rb;
        logic rc;
        for (int i = 0; i < 30; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            hold = $urandom_range(0, 3);
            out_ready = (hold == 0);
            model(16, ra, rb, rc, es, ec, eo, ez);
            op16(ra, rb, rc, lat);
            checks++;
            if (lat !== 4 || {sum, cout, overflow, zero} !== {16'(es), 1'(ec), 1'(eo), 1'(ez)}) begin
                errors++;
                $display("FAIL rand%0d: a=%h b=%h cin=%b got lat=%0d sum=%h c=%b o=%b z=%b want lat=4 sum=%h c=%0d o=%0d z=%0d",
                         i, ra, rb, rc, lat, sum, cout, overflow, zero, 16'(es), ec, eo, ez);
            end
            repeat (hold) begin @(posedge clk); #1; end
            out_ready = 1'b1;
            @(posedge clk); #1;
            checks++;
            if ({out_valid, in_ready} !== 2'b01) begin
                errors++; $display("FAIL rand%0d_release: got vld=%b rdy=%b want vld=0 rdy=1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat, es, ec, eo, ez, bad;
        out_ready = 1'b0;
        model(16, 16'hA5A5, 16'h1111, 1, es, ec, eo, ez);
        op16(16'hA5A5, 16'h1111, 1'b1, lat);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            a = 16'h0001; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
            @(posedge clk); #1;
            if ({out_valid, in_ready, sum, cout, overflow, zero} !== {2'b10, 16'(es), 1'(ec), 1'(eo), 1'(ez)}) bad++;
        end
        checks++;
        if (lat !== 4 || bad !== 0) begin
            errors++;
            $display("FAIL backpressure_hold: got lat=%0d unstable_cycles=%0d sum=%h want lat=4 unstable_cycles=0 sum=%h",
                     lat, bad, sum, 16'(es));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++; $display("FAIL backpressure_release: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
        end
        bad = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL backpressure_no_accept: got %0d busy cycles want 0", bad);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, bad;
        out_ready = 1'b1;
        a = 16'h1234; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, sum} !== {2'b01, 16'h0000}) begin
            errors++;
            $display("FAIL midrun_reset: got vld=%b rdy=%b sum=%h want vld=0 rdy=1 sum=0000", out_valid, in_ready, sum);
        end
        @(negedge clk); rst_n = 1'b1;
        bad = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL midrun_discard: got %0d valid cycles want 0", bad);
        end
        op16(16'h0F0F, 16'h00F1, 1'b0, lat);
        checks++;
        if (lat !== 4 || {sum, cout, overflow, zero} !== {16'h1000, 3'b000}) begin
            errors++;
            $display("FAIL midrun_next_op: got lat=%0d sum=%h c=%b o=%b z=%b want lat=4 sum=1000 flags=000",
                     lat, sum, cout, overflow, zero);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_width4();
        int lat, es, ec, eo, ez;
        logic [3:0] ra, rb;
        logic rc;
        out_ready4 = 1'b1;
        op4(4'hF, 4'hF, 1'b1, lat);
        checks++;
        if (lat !== 1 || {sum4, cout4, overflow4, zero4} !== {4'hF, 3'b100}) begin
            errors++;
            $display("FAIL w4_allones: got lat=%0d sum=%h c=%b o=%b z=%b want lat=1 sum=f c=1 o=0 z=0",
                     lat, sum4, cout4, overflow4, zero4);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 12; i++) begin
            ra = 4'($urandom); rb = 4'($urandom); rc = 1'($urandom);
            model(4, ra, rb, rc, es, ec, eo, ez);
            op4(ra, rb, rc, lat);
            checks++;
            if (lat !== 1 || {sum4, cout4, overflow4, zero4} !== {4'(es), 1'(ec), 1'(eo), 1'(ez)}) begin
                errors++;
                $display("FAIL w4_rand%0d: a=%h b=%h cin=%b got lat=%0d sum=%h c=%b o=%b z=%b want lat=1 sum=%h c=%0d o=%0d z=%0d",
                         i, ra, rb, rc, lat, sum4, cout4, overflow4, zero4, 4'(es), ec, eo, ez);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_run();
        test_width4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Multi-cycle WIDTH-bit adder that processes one 4-bit nibble of each operand per clock through a single CLA_4bit instance, LSB nibble first. A carry register links consecutive nibbles. Operands enter, and the result leaves, over valid/ready handshakes. It is the sequencing stage that feeds the 4-bit CLA and consumes its Sum/Cout, for area-reduced ALU datapaths.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and ≥ 4 (elaboration error otherwise).
NIB, WIDTH/4, derived local constant: number of nibble steps.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand request valid
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in to nibble 0
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  A+B+cin, low WIDTH bits
cout  output  1  carry out of the MSB nibble
overflow  output  1  two's-complement signed overflow
zero  output  1  sum == 0

Behaviour:
- Single clock domain: clk. Reset: asynchronous, active-low (rst_n); all state is cleared immediately on assertion and released on the next clk edge after deassertion.
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, overflow=0, zero=0, internal operand, carry and index registers=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at a clk edge: latch a and b, set carry_reg=cin, set idx=0, go to RUN.
- RUN:
  - in_ready=0; in_valid is ignored.
  - Each cycle, drive CLA_4bit with A=a_reg[4*idx+:4], B=b_reg[4*idx+:4], Cin=carry_reg.
  - At the edge: sum_reg[4*idx+:4] <= Sum, carry_reg <= Cout, idx <= idx+1.
  - At the edge where idx==NIB-1: go to DONE. Also at that edge: cout <= Cout; overflow <= (a_reg[WIDTH-1]==b_reg[WIDTH-1]) && (final sum MSB != a_reg[WIDTH-1]); zero <= all sum bits 0, including the nibble being written.
  - Xout/Yout of CLA_4bit are left unconnected.
- DONE:
  - out_valid=1.
  - sum, cout, overflow and zero are held stable until out_valid&&out_ready.
  - On that handshake: out_valid <= 0, go to IDLE.
  - in_ready=0 in DONE, so no same-cycle turnaround.
- Latency: operand handshake at edge E → out_valid high after edge E+NIB (NIB=4 gives 4 cycles). Minimum initiation interval is NIB+2 cycles.
- Outputs are registered. sum is only guaranteed meaningful while out_valid=1, but it must not glitch during DONE.
- Boundary conditions:
  - cin=1 with a=b=all-ones → sum=all-ones, cout=1.
  - out_ready held low indefinitely → remain in DONE with outputs frozen.
  - out_ready high before out_valid → no effect.
  - rst_n asserted in RUN or DONE → in-flight operation is discarded and no result is emitted.
  - idx width is clog2(NIB), minimum 1 bit. idx never wraps past NIB-1.
  - WIDTH=4 → single RUN cycle.

Decomposition:
- Shared ALU package: FSM state enum (IDLE/RUN/DONE, 2-bit encoding) and the NIBBLE_W=4 constant.
- Single sub-module: the existing CLA_4bit, instantiated once. No other hierarchy.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, cin=0, out_ready=1 → after 4 cycles sum=0x5555, cout=0, overflow=0, zero=0; out_valid high for exactly 1 cycle.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, zero=1, overflow=0; confirms carry ripples through all 4 nibble steps.
- a=0x7FFF, b=0x0000, cin=1 → sum=0x8000, overflow=1, cout=0. Then a=0x8000, b=0x8000, cin=0 → sum=0x0000, cout=1, overflow=1, zero=1.
- Backpressure: out_ready=0 for 10 cycles after out_valid → sum/flags stable, in_ready=0; a second in_valid pulse is not accepted. After out_ready=1: handshake, return to IDLE, in_ready=1 next cycle.
- Reset mid-RUN: assert rst_n=0 after 2 RUN cycles → out_valid=0, sum=0, in_ready=1 immediately. A new op a=0x0F0F, b=0x00F1, cin=0 → sum=0x1000.
- WIDTH=4 instance: a=0xF, b=0xF, cin=1 → sum=0xF, cout=1, latency 1 cycle.
